// File: rtl/conv_pe_avalon_mm.sv
// conv_pe_avalon_mm: Avalon-MM convolution processing element.
// Computes one output pixel: sum over NUM_CH channels of a KxK image window
// dotted with a KxK filter, plus bias, with optional ReLU. A sequential MAC
// engine issues one product per cycle with saturating accumulation.
module conv_pe_avalon_mm #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 32
) (
    input  logic        csi_clockreset_clk,
    input  logic        csi_clockreset_reset,
    input  logic [7:0]  avs_s1_address,
    input  logic        avs_s1_read,
    input  logic        avs_s1_write,
    input  logic [31:0] avs_s1_writedata,
    output logic [31:0] avs_s1_readdata,
    output logic        ins_irq_irq
);

    localparam int N = K * K * NUM_CH;

    localparam logic [6:0] N_ENTRIES = 7'(N);
    localparam logic [5:0] LAST_IDX  = 6'(N - 1);

    localparam logic [7:0] A_CTRL   = 8'h80;
    localparam logic [7:0] A_BIAS   = 8'h81;
    localparam logic [7:0] A_STATUS = 8'h82;
    localparam logic [7:0] A_RESULT = 8'h83;
    localparam logic [7:0] A_CYCLES = 8'h84;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Signed add with clamp; the extra MSB of the return value flags overflow.
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W-1:0] s;
        logic                    ov;
        s  = a + b;
        ov = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        if (ov) begin
            s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
        return {ov, s};
    endfunction

    // Optional rectification of the final sum.
    function automatic logic signed [ACC_W-1:0] relu(
        input logic                    en,
        input logic signed [ACC_W-1:0] v
    );
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction

    // Operand storage and control/status state
    logic signed [DATA_W-1:0] r_img [N];
    logic signed [DATA_W-1:0] r_flt [N];
    logic signed [ACC_W-1:0]  r_bias;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_result;
    logic [5:0]               r_idx;
    logic [7:0]               r_cyc;
    logic [7:0]               r_cycles;
    logic                     r_relu_en;
    logic                     r_irq_en;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_ovf;
    logic                     r_err;
    state_t                   r_state;
    state_t                   w_state_nxt;

    // Bus decode
    logic                     w_img_hit;
    logic                     w_flt_hit;
    logic [5:0]               w_widx;
    logic                     w_ctrl_wr;
    logic                     w_reg_wr;
    logic                     w_start;
    logic                     w_clear;
    logic signed [31:0]       w_wdata_s;
    logic [31:0]              w_rd_data;

    // Datapath
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W:0]             w_mac_res;
    logic [ACC_W:0]             w_post_res;
    logic signed [ACC_W-1:0]    w_mac_sum;
    logic signed [ACC_W-1:0]    w_post_sum;
    logic                       w_mac_ovf;
    logic                       w_post_ovf;

    // FSM stage decodes
    logic w_mac_en;
    logic w_post_en;
    logic w_done_en;

    assign w_widx    = avs_s1_address[5:0];
    assign w_img_hit = (avs_s1_address[7:6] == 2'b00) && ({1'b0, w_widx} < N_ENTRIES);
    assign w_flt_hit = (avs_s1_address[7:6] == 2'b01) && ({1'b0, w_widx} < N_ENTRIES);
    assign w_ctrl_wr = avs_s1_write && (avs_s1_address == A_CTRL);
    assign w_reg_wr  = avs_s1_write &&
                       (w_img_hit || w_flt_hit ||
                        (avs_s1_address == A_CTRL) || (avs_s1_address == A_BIAS));
    assign w_start   = w_ctrl_wr && !r_busy && avs_s1_writedata[0];
    assign w_clear   = w_ctrl_wr && !r_busy && avs_s1_writedata[3];
    assign w_wdata_s = avs_s1_writedata;

    assign w_prod     = (2*DATA_W)'(r_img[r_idx]) * (2*DATA_W)'(r_flt[r_idx]);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_mac_res  = sat_add(r_acc, w_prod_ext);
    assign w_post_res = sat_add(r_acc, r_bias);
    assign w_mac_sum  = w_mac_res[ACC_W-1:0];
    assign w_mac_ovf  = w_mac_res[ACC_W];
    assign w_post_sum = w_post_res[ACC_W-1:0];
    assign w_post_ovf = w_post_res[ACC_W];

    assign ins_irq_irq = r_done && r_irq_en;

    // FSM state register
    always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: a start leaves IDLE, MAC runs N cycles, POST and DONE take one each
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_MAC;
            S_MAC:  if (r_idx == LAST_IDX) w_state_nxt = S_POST;
            S_POST: w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: one enable per working state
    always_comb begin
        w_mac_en  = 1'b0;
        w_post_en = 1'b0;
        w_done_en = 1'b0;
        case (r_state)
            S_MAC:  w_mac_en  = 1'b1;
            S_POST: w_post_en = 1'b1;
            S_DONE: w_done_en = 1'b1;
            default: ;
        endcase
    end

    // Operand registers, accumulator, and status flags
    always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
            for (int i = 0; i < N; i++) begin
                r_img[i] <= '0;
                r_flt[i] <= '0;
            end
            r_bias    <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_idx     <= '0;
            r_cyc     <= '0;
            r_cycles  <= '0;
            r_relu_en <= 1'b0;
            r_irq_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Operand writes are only accepted between runs
            if (avs_s1_write && !r_busy) begin
                if (w_img_hit) r_img[w_widx] <= avs_s1_writedata[DATA_W-1:0];
                if (w_flt_hit) r_flt[w_widx] <= avs_s1_writedata[DATA_W-1:0];
                if (avs_s1_address == A_BIAS) r_bias <= ACC_W'(w_wdata_s);
            end

            // Writes that would disturb a run in progress are flagged, not applied
            if (w_reg_wr && r_busy) begin
                r_err <= 1'b1;
            end else if (w_clear) begin
                r_err <= 1'b0;
            end

            if (w_start) begin
                r_relu_en <= avs_s1_writedata[1];
                r_irq_en  <= avs_s1_writedata[2];
                r_acc     <= '0;
                r_idx     <= '0;
                r_cyc     <= '0;
                r_ovf     <= 1'b0;
                r_done    <= 1'b0;
                r_busy    <= 1'b1;
            end else if (w_clear) begin
                r_done <= 1'b0;
            end

            // MAC stage: one product per cycle, clamped on overflow
            if (w_mac_en) begin
                r_acc <= w_mac_sum;
                r_idx <= r_idx + 6'd1;
                r_cyc <= r_cyc + 8'd1;
                if (w_mac_ovf) r_ovf <= 1'b1;
            end

            // POST stage: bias, optional ReLU, publish result
            if (w_post_en) begin
                r_acc    <= relu(r_relu_en, w_post_sum);
                r_result <= relu(r_relu_en, w_post_sum);
                r_cyc    <= r_cyc + 8'd1;
                if (w_post_ovf) r_ovf <= 1'b1;
            end

            // DONE stage: count includes this cycle
            if (w_done_en) begin
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_cycles <= r_cyc + 8'd1;
            end
        end
    end

    // Read mux; sampled into readdata on the edge that ends the read cycle
    always_comb begin
        w_rd_data = '0;
        if (w_img_hit) begin
            w_rd_data = 32'(r_img[w_widx]);
        end else if (w_flt_hit) begin
            w_rd_data = 32'(r_flt[w_widx]);
        end else begin
            case (avs_s1_address)
                A_BIAS:   w_rd_data = 32'(r_bias);
                A_STATUS: w_rd_data = {28'd0, r_err, r_ovf, r_done, r_busy};
                A_RESULT: w_rd_data = 32'(r_result);
                A_CYCLES: w_rd_data = {24'd0, r_cycles};
                default:  w_rd_data = '0;
            endcase
        end
    end

    // Registered read data, fixed latency of one cycle
    always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
            avs_s1_readdata <= '0;
        end else if (avs_s1_read) begin
            avs_s1_readdata <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_conv_pe_avalon_mm.sv
// Directed bench for conv_pe_avalon_mm. A default build (ACC_W=32) and a
// narrow build (ACC_W=16) share the bus inputs and are checked side by side.
module tb_conv_pe_avalon_mm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = '0;
    logic        rd_s = 1'b0;
    logic        wr_s = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [31:0] rdata16;
    logic        irq;
    logic        irq16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_pe_avalon_mm dut (
        .csi_clockreset_clk   (clk),
        .csi_clockreset_reset (rst),
        .avs_s1_address       (addr),
        .avs_s1_read          (rd_s),
        .avs_s1_write         (wr_s),
        .avs_s1_writedata     (wdata),
        .avs_s1_readdata      (rdata),
        .ins_irq_irq          (irq)
    );

    conv_pe_avalon_mm #(.ACC_W(16)) dut16 (
        .csi_clockreset_clk   (clk),
        .csi_clockreset_reset (rst),
        .avs_s1_address       (addr),
        .avs_s1_read          (rd_s),
        .avs_s1_write         (wr_s),
        .avs_s1_writedata     (wdata),
        .avs_s1_readdata      (rdata16),
        .ins_irq_irq          (irq16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_s = 1'b1;
        @(negedge clk);
        wr_s = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d, output logic [31:0] d16);
        addr = a; rd_s = 1'b1;
        @(negedge clk);
        rd_s = 1'b0;
        d = rdata; d16 = rdata16;
    endtask

    task automatic fill(input logic [7:0] base, input logic [31:0] d);
        for (int i = 0; i < 36; i++) bus_wr(base + 8'(i), d);
    endtask

    // Poll STATUS every cycle; returns number of cycles busy was seen
    task automatic run_wait(output int busy_n);
        logic seen;
        seen = 1'b0; busy_n = 0;
        addr = 8'h82; rd_s = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdata[1]) begin
                seen = 1'b1;
                break;
            end
            if (rdata[0]) busy_n++;
        end
        rd_s = 1'b0;
        chk("run_done_seen", {31'd0, seen}, 32'd1);
    endtask

    logic [31:0] d, d16;
    int          nb;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        bus_rd(8'h82, d, d16); chk("rst_status", d, 32'd0);
        bus_rd(8'h83, d, d16); chk("rst_result", d, 32'd0);
        bus_rd(8'h84, d, d16); chk("rst_cycles", d, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // All ones: 36 products of 1
        fill(8'h00, 32'd1);
        fill(8'h40, 32'd1);
        bus_wr(8'h81, 32'd0);
        bus_wr(8'h80, 32'd1);
        run_wait(nb);
        chk("ones_busy_cycles", 32'(nb), 32'd38);
        bus_rd(8'h83, d, d16); chk("ones_result", d, 32'd36); chk("ones_result16", d16, 32'd36);
        bus_rd(8'h84, d, d16); chk("ones_cycles", d, 32'd38);
        bus_rd(8'h82, d, d16); chk("ones_status", d, 32'h2);

        // -128 * -128 * 36 + 5; narrow build saturates
        fill(8'h00, 32'hFFFF_FF80);
        fill(8'h40, 32'hFFFF_FF80);
        bus_wr(8'h81, 32'd5);
        bus_rd(8'h40, d, d16); chk("flt_readback", d, 32'hFFFF_FF80);
        bus_wr(8'h80, 32'd1);
        run_wait(nb);
        bus_rd(8'h83, d, d16); chk("neg_result", d, 32'd589829); chk("sat_result16", d16, 32'h0000_7FFF);
        bus_rd(8'h82, d, d16); chk("neg_status", d, 32'h2); chk("sat_status16", d16, 32'h6);

        // Large negative bias with ReLU clamps to zero
        bus_wr(8'h81, 32'hFFF6_D840);
        bus_wr(8'h80, 32'd3);
        run_wait(nb);
        bus_rd(8'h83, d, d16); chk("relu_result", d, 32'd0);

        // Zero image clears ovf on the next run
        fill(8'h00, 32'd0);
        bus_wr(8'h81, 32'd0);
        bus_wr(8'h80, 32'd1);
        run_wait(nb);
        bus_rd(8'h83, d, d16); chk("zero_result", d, 32'd0); chk("zero_result16", d16, 32'd0);
        bus_rd(8'h82, d, d16); chk("zero_status16", d16, 32'h2);

        // Writes while busy are rejected and flagged
        fill(8'h00, 32'd2);
        fill(8'h40, 32'd1);
        bus_wr(8'h80, 32'd1);
        bus_wr(8'h00, 32'd7);
        bus_wr(8'h80, 32'd1);
        run_wait(nb);
        bus_rd(8'h83, d, d16); chk("err_result", d, 32'd72);
        bus_rd(8'h82, d, d16); chk("err_status", d, 32'hA);
        bus_rd(8'h00, d, d16); chk("err_img0_kept", d, 32'd2);
        bus_rd(8'h84, d, d16); chk("err_cycles", d, 32'd38);
        bus_wr(8'h80, 32'd8);
        bus_rd(8'h82, d, d16); chk("clear_status", d, 32'h0);

        // Interrupt follows done when enabled
        bus_wr(8'h80, 32'd5);
        chk("irq_busy", {31'd0, irq}, 32'd0);
        run_wait(nb);
        chk("irq_done", {31'd0, irq}, 32'd1);
        bus_wr(8'h80, 32'd8);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // Asynchronous reset in the middle of MAC
        bus_wr(8'h80, 32'd1);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        bus_rd(8'h82, d, d16); chk("midrst_status", d, 32'h0);
        bus_rd(8'h83, d, d16); chk("midrst_result", d, 32'd0);
        bus_rd(8'h00, d, d16); chk("midrst_img0", d, 32'd0);

        // Same-cycle read and write returns the old value
        addr = 8'h05; wdata = 32'd9; rd_s = 1'b1; wr_s = 1'b1;
        @(negedge clk);
        rd_s = 1'b0; wr_s = 1'b0;
        chk("rw_old_value", rdata, 32'd0);
        bus_rd(8'h05, d, d16); chk("rw_new_value", d, 32'd9);

        // Fresh run after reset: 4*(3*-2) + 100 = 76
        for (int i = 0; i < 4; i++) begin
            bus_wr(8'(i), 32'd3);
            bus_wr(8'h40 + 8'(i), 32'hFFFF_FFFE);
        end
        bus_wr(8'h81, 32'd100);
        bus_wr(8'h80, 32'd1);
        run_wait(nb);
        chk("fresh_busy_cycles", 32'(nb), 32'd38);
        bus_rd(8'h83, d, d16); chk("fresh_result", d, 32'd76); chk("fresh_result16", d16, 32'd76);
        bus_rd(8'h84, d, d16); chk("fresh_cycles", d, 32'd38);
        bus_rd(8'h99, d, d16); chk("unmapped_read", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
